// File: rtl/mm2s_sched_pkg.sv
// rtl/mm2s_sched_pkg.sv - shared types and helpers for the MM2S frame scheduler
package mm2s_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_t;

  localparam int BUF_MAX   = 8;
  localparam int BUF_IDX_W = 3;

  typedef logic [BUF_IDX_W-1:0] buf_idx_t;

  // Lowest index whose busy bit is clear; callers guarantee one exists.
  function automatic buf_idx_t next_free_idx(input logic [BUF_MAX-1:0] busy);
    next_free_idx = '0;
    for (int i = BUF_MAX - 1; i >= 0; i--) begin
      if (!busy[i]) next_free_idx = buf_idx_t'(i);
    end
  endfunction

endpackage

// File: rtl/mm2s_buf_rotator.sv
// rtl/mm2s_buf_rotator.sv - frame buffer index registers and rotation rules
module mm2s_buf_rotator
  import mm2s_sched_pkg::*;
#(
  parameter int C_BUF_NUM = 3
) (
  input  logic                 clk_i,
  input  logic                 resetn_i,
  input  logic                 run_i,
  input  logic                 clear_i,
  input  logic                 wr_done_i,
  input  logic                 rd_frame_pulse_i,
  output logic [BUF_IDX_W-1:0] rd_idx_o,
  output logic [BUF_IDX_W-1:0] wr_idx_o
);

  buf_idx_t           rd_idx_q, rd_idx_d;
  buf_idx_t           wr_idx_q, wr_idx_d;
  buf_idx_t           latest_idx_q, latest_idx_d;
  logic               latest_valid_q, latest_valid_d;
  logic [BUF_MAX-1:0] busy;

  always_comb begin
    rd_idx_d       = rd_idx_q;
    wr_idx_d       = wr_idx_q;
    latest_idx_d   = latest_idx_q;
    latest_valid_d = latest_valid_q;
    // Slots beyond the configured buffer count are never handed out.
    for (int i = 0; i < BUF_MAX; i++) begin
      busy[i] = (i >= C_BUF_NUM);
    end
    if (clear_i) begin
      rd_idx_d       = buf_idx_t'(0);
      wr_idx_d       = buf_idx_t'(1);
      latest_idx_d   = buf_idx_t'(0);
      latest_valid_d = 1'b0;
    end else if (run_i) begin
      if (wr_done_i && rd_frame_pulse_i) begin
        // Reader jumps straight onto the frame just finished.
        busy[wr_idx_q] = 1'b1;
        rd_idx_d       = wr_idx_q;
        latest_valid_d = 1'b0;
        wr_idx_d       = next_free_idx(busy);
      end else if (wr_done_i) begin
        busy[wr_idx_q] = 1'b1;
        busy[rd_idx_q] = 1'b1;
        latest_idx_d   = wr_idx_q;
        latest_valid_d = 1'b1;
        wr_idx_d       = next_free_idx(busy);
      end else if (rd_frame_pulse_i && latest_valid_q) begin
        rd_idx_d       = latest_idx_q;
        latest_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      rd_idx_q       <= buf_idx_t'(0);
      wr_idx_q       <= buf_idx_t'(1);
      latest_idx_q   <= buf_idx_t'(0);
      latest_valid_q <= 1'b0;
    end else begin
      rd_idx_q       <= rd_idx_d;
      wr_idx_q       <= wr_idx_d;
      latest_idx_q   <= latest_idx_d;
      latest_valid_q <= latest_valid_d;
    end
  end

  assign rd_idx_o = rd_idx_q;
  assign wr_idx_o = wr_idx_q;

endmodule

// File: rtl/mm2s_frame_sched.sv
// rtl/mm2s_frame_sched.sv - MM2S frame buffer scheduler and run/stop sequencer (optional MM2S_FSYNC_GEN_EN)
module mm2s_frame_sched
  import mm2s_sched_pkg::*;
#(
  parameter int                C_ADDR_WIDTH   = 32,
  parameter int                C_BUF_NUM      = 3,
  parameter int                C_BUF_IDX_BITS = 3,
  parameter logic [31:0]       C_BUF_STRIDE   = 32'h0080_0000,
  parameter int                C_FSYNC_PERIOD = 1666666,
  parameter int                C_FSYNC_HIGH   = 16
) (
  input  logic                      M_AXI_ACLK,
  input  logic                      M_AXI_ARESETN,
  input  logic                      enable,
  input  logic [C_ADDR_WIDTH-1:0]   buf_base,
  input  logic                      fsync_in,
  input  logic                      wr_done,
  input  logic                      rd_frame_pulse,
  input  logic                      rd_resetting,
  output logic                      rd_soft_resetn,
  output logic                      rd_fsync,
  output logic [C_ADDR_WIDTH-1:0]   rd_base_addr,
  output logic [C_ADDR_WIDTH-1:0]   wr_base_addr,
  output logic [C_BUF_IDX_BITS-1:0] rd_idx,
  output logic [C_BUF_IDX_BITS-1:0] wr_idx,
  output logic                      running
);

  localparam logic [C_ADDR_WIDTH-1:0] STRIDE = C_ADDR_WIDTH'(C_BUF_STRIDE);

  sched_state_t              state_q, state_d;
  logic [1:0]                drain_cnt_q, drain_cnt_d;
  logic                      soft_resetn_q;
  logic [C_ADDR_WIDTH-1:0]   rd_addr_q, wr_addr_q;
  logic [BUF_IDX_W-1:0]      rd_idx_w, wr_idx_w;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = 2'd0;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: begin
        // Hold off at least three cycles so the reader sees its reset.
        drain_cnt_d = (drain_cnt_q == 2'd2) ? 2'd2 : drain_cnt_q + 2'd1;
        if (drain_cnt_q == 2'd2 && !rd_resetting) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q       <= ST_IDLE;
      drain_cnt_q   <= 2'd0;
      soft_resetn_q <= 1'b0;
      rd_addr_q     <= '0;
      wr_addr_q     <= '0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      soft_resetn_q <= (state_d == ST_RUN);
      rd_addr_q     <= buf_base + STRIDE * C_ADDR_WIDTH'(rd_idx_w);
      wr_addr_q     <= buf_base + STRIDE * C_ADDR_WIDTH'(wr_idx_w);
    end
  end

  mm2s_buf_rotator #(
    .C_BUF_NUM (C_BUF_NUM)
  ) u_rotator (
    .clk_i            (M_AXI_ACLK),
    .resetn_i         (M_AXI_ARESETN),
    .run_i            (state_q == ST_RUN),
    .clear_i          (state_d == ST_IDLE),
    .wr_done_i        (wr_done),
    .rd_frame_pulse_i (rd_frame_pulse),
    .rd_idx_o         (rd_idx_w),
    .wr_idx_o         (wr_idx_w)
  );

`ifdef MM2S_FSYNC_GEN_EN
  logic [31:0] fs_cnt_q;
  logic        unused_fsync_in;

  assign unused_fsync_in = fsync_in;

  // Counter parked at zero outside RUN so the first pulse lands on entry.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN || state_q != ST_RUN) begin
      fs_cnt_q <= '0;
    end else if (fs_cnt_q == 32'(C_FSYNC_PERIOD - 1)) begin
      fs_cnt_q <= '0;
    end else begin
      fs_cnt_q <= fs_cnt_q + 32'd1;
    end
  end

  assign rd_fsync = (state_q == ST_RUN) && (fs_cnt_q < 32'(C_FSYNC_HIGH));
`else
  localparam int unused_fsync_cfg = C_FSYNC_PERIOD + C_FSYNC_HIGH;
  logic fsync_q;

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) fsync_q <= 1'b0;
    else                fsync_q <= fsync_in;
  end

  assign rd_fsync = fsync_q && (state_q == ST_RUN);
`endif

  assign running        = (state_q == ST_RUN);
  assign rd_soft_resetn = soft_resetn_q;
  assign rd_base_addr   = rd_addr_q;
  assign wr_base_addr   = wr_addr_q;
  assign rd_idx         = C_BUF_IDX_BITS'(rd_idx_w);
  assign wr_idx         = C_BUF_IDX_BITS'(wr_idx_w);

endmodule
